// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

  // Controller states: serve from cache, fetch a block, install the line.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  localparam int TAG_BITS        = 3;
  localparam int OFFSET_BITS     = 2;
  localparam int WORDS_PER_BLOCK = 4;

  // Bit positions of the fields inside the CPU byte address.
  localparam int OFFSET_LSB = 2;
  localparam int INDEX_LSB  = 4;
  localparam int TAG_LSB    = 7;

  // Pick one 32-bit word out of a 128-bit block; offset 0 is the low word.
  function automatic logic [31:0] select_word(input logic [127:0] block,
                                              input logic [OFFSET_BITS-1:0] offset);
    logic [31:0] word;
    case (offset)
      2'd0:    word = block[31:0];
      2'd1:    word = block[63:32];
      2'd2:    word = block[95:64];
      2'd3:    word = block[127:96];
      default: word = block[31:0];
    endcase
    return word;
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the cache lines with a combinational lookup port.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int BLOCK_BITS = 128
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [INDEX_BITS-1:0] rd_index,
  input  logic [TAG_BITS-1:0]   rd_tag,
  output logic                  rd_hit,
  output logic [BLOCK_BITS-1:0] rd_block,
  input  logic                  data_we,
  input  logic                  tag_we,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [BLOCK_BITS-1:0] wr_block
);

  localparam int LINES = 2 ** INDEX_BITS;

  logic [LINES-1:0]      valid_r;
  logic [TAG_BITS-1:0]   tag_r  [LINES];
  logic [BLOCK_BITS-1:0] data_r [LINES];

  // Valid bits: cleared asynchronously, set when a line is installed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= {LINES{1'b0}};
    end else if (tag_we) begin
      valid_r[wr_index] <= 1'b1;
    end
  end

  // Tag array: written together with the valid bit.
  always_ff @(posedge clock) begin
    if (tag_we) begin
      tag_r[wr_index] <= wr_tag;
    end
  end

  // Data array: the refill block lands here one cycle before the tag.
  always_ff @(posedge clock) begin
    if (data_we) begin
      data_r[wr_index] <= wr_block;
    end
  end

  assign rd_hit   = valid_r[rd_index] & (tag_r[rd_index] == rd_tag);
  assign rd_block = data_r[rd_index];

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache: lookup, miss sequencing and hit/miss counters.
module icache_controller
  import icache_pkg::*;
#(
  parameter int ADDR_BITS  = 10,
  parameter int INDEX_BITS = 3,
  parameter int BLOCK_BITS = 128,
  parameter int CNT_BITS   = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cpu_read,
  input  logic [ADDR_BITS-1:0]  cpu_address,
  output logic [31:0]           cpu_instruction,
  output logic                  cpu_busywait,
  output logic                  mem_read,
  output logic [ADDR_BITS-5:0]  mem_address,
  input  logic [BLOCK_BITS-1:0] mem_readdata,
  input  logic                  mem_busywait,
  output logic [CNT_BITS-1:0]   hit_count,
  output logic [CNT_BITS-1:0]   miss_count
);

  logic [TAG_BITS-1:0]    tag_s;
  logic [INDEX_BITS-1:0]  index_s;
  logic [OFFSET_BITS-1:0] offset_s;
  logic                   unused_s;

  logic                   line_hit_s;
  logic [BLOCK_BITS-1:0]  line_block_s;

  state_t                 state_r;
  state_t                 next_s;
  logic                   entry_r;
  logic                   mem_read_r;
  logic [ADDR_BITS-5:0]   mem_address_r;
  logic [CNT_BITS-1:0]    hit_count_r;
  logic [CNT_BITS-1:0]    miss_count_r;

  logic                   hit_done_s;
  logic                   miss_start_s;
  logic                   refill_done_s;
  logic                   install_s;
  logic                   busy_s;
  logic [31:0]            instr_s;

  assign tag_s    = cpu_address[TAG_LSB +: TAG_BITS];
  assign index_s  = cpu_address[INDEX_LSB +: INDEX_BITS];
  assign offset_s = cpu_address[OFFSET_LSB +: OFFSET_BITS];
  assign unused_s = ^cpu_address[1:0];

  icache_line_store #(
    .INDEX_BITS (INDEX_BITS),
    .BLOCK_BITS (BLOCK_BITS)
  ) u_line_store (
    .clock    (clock),
    .reset_n  (reset_n),
    .rd_index (index_s),
    .rd_tag   (tag_s),
    .rd_hit   (line_hit_s),
    .rd_block (line_block_s),
    .data_we  (refill_done_s),
    .tag_we   (install_s),
    .wr_index (mem_address_r[INDEX_BITS-1:0]),
    .wr_tag   (mem_address_r[INDEX_BITS +: TAG_BITS]),
    .wr_block (mem_readdata)
  );

  // Next-state decode plus the one-cycle strobes that drive storage and counters.
  always_comb begin
    next_s        = state_r;
    hit_done_s    = 1'b0;
    miss_start_s  = 1'b0;
    refill_done_s = 1'b0;
    install_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (cpu_read) begin
          if (line_hit_s) begin
            hit_done_s = 1'b1;
            next_s     = IDLE;
          end else begin
            miss_start_s = 1'b1;
            next_s       = MEM_READ;
          end
        end else begin
          next_s = IDLE;
        end
      end
      MEM_READ: begin
        // The first MEM_READ cycle precedes any memory reaction, so busywait is not trusted yet.
        if (!entry_r && !mem_busywait) begin
          refill_done_s = 1'b1;
          next_s        = UPDATE;
        end else begin
          next_s = MEM_READ;
        end
      end
      UPDATE: begin
        install_s = 1'b1;
        next_s    = IDLE;
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // CPU-facing outputs: stall on a miss or while refilling, forced quiet during reset.
  always_comb begin
    busy_s  = 1'b0;
    instr_s = 32'h0000_0000;
    if (!reset_n) begin
      busy_s  = 1'b0;
      instr_s = 32'h0000_0000;
    end else if (state_r != IDLE) begin
      busy_s  = 1'b1;
      instr_s = 32'h0000_0000;
    end else if (hit_done_s) begin
      busy_s  = 1'b0;
      instr_s = select_word(line_block_s, offset_s);
    end else begin
      busy_s  = miss_start_s;
      instr_s = 32'h0000_0000;
    end
  end

  // State, memory request and block address registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      entry_r       <= 1'b0;
      mem_read_r    <= 1'b0;
      mem_address_r <= {(ADDR_BITS-4){1'b0}};
    end else begin
      state_r    <= next_s;
      entry_r    <= miss_start_s;
      mem_read_r <= (next_s == MEM_READ);
      if (miss_start_s) begin
        mem_address_r <= {tag_s, index_s};
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_count_r  <= {CNT_BITS{1'b0}};
      miss_count_r <= {CNT_BITS{1'b0}};
    end else begin
      if (hit_done_s && (hit_count_r != {CNT_BITS{1'b1}})) begin
        hit_count_r <= hit_count_r + {{(CNT_BITS-1){1'b0}}, 1'b1};
      end
      if (miss_start_s && (miss_count_r != {CNT_BITS{1'b1}})) begin
        miss_count_r <= miss_count_r + {{(CNT_BITS-1){1'b0}}, 1'b1};
      end
    end
  end

  assign cpu_busywait    = busy_s;
  assign cpu_instruction = instr_s;
  assign mem_read        = mem_read_r;
  assign mem_address     = mem_address_r;
  assign hit_count       = hit_count_r;
  assign miss_count      = miss_count_r;

endmodule

// File: tb/tb_icache_controller.sv
// Directed testbench for icache_controller with a small inst_memory model.
module tb_icache_controller;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         cpu_read;
  logic [9:0]   cpu_address;
  logic [31:0]  cpu_instruction;
  logic         cpu_busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  logic [127:0] imem [64];
  logic [1:0]   mem_cnt = 2'd0;

  int n_cmp = 0;
  int n_err = 0;
  int exp_hit = 0;
  int exp_miss = 0;

  icache_controller dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .cpu_read        (cpu_read),
    .cpu_address     (cpu_address),
    .cpu_instruction (cpu_instruction),
    .cpu_busywait    (cpu_busywait),
    .mem_read        (mem_read),
    .mem_address     (mem_address),
    .mem_readdata    (mem_readdata),
    .mem_busywait    (mem_busywait),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  always #5 clock = ~clock;

  // Memory model: busywait low on the request's first cycle, busy for two, then ready.
  assign mem_readdata = imem[mem_address];
  assign mem_busywait = mem_read && (mem_cnt != 2'd0) && (mem_cnt != 2'd3);

  always @(posedge clock) begin
    if (!mem_read) mem_cnt <= 2'd0;
    else if (mem_cnt != 2'd3) mem_cnt <= mem_cnt + 2'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Wait for the stall to clear; a refill takes 5 cycles after the miss edge.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (cpu_busywait && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(n), 32'd5);
  endtask

  task automatic do_miss(input logic [9:0] a, input logic [5:0] exp_ma, input logic [31:0] exp_ins);
    cpu_address = a;
    cpu_read = 1'b1;
    #1;
    chk("miss_busy", 32'(cpu_busywait), 32'd1);
    chk("miss_memrd_idle", 32'(mem_read), 32'd0);
    tick();
    exp_miss++;
    chk("mem_read", 32'(mem_read), 32'd1);
    chk("mem_address", 32'(mem_address), 32'(exp_ma));
    chk("miss_count", 32'(miss_count), 32'(exp_miss));
    wait_ready("refill_lat");
    chk("miss_instr", cpu_instruction, exp_ins);
    chk("memrd_done", 32'(mem_read), 32'd0);
    tick();
    exp_hit++;
    cpu_read = 1'b0;
    chk("miss_hitcnt", 32'(hit_count), 32'(exp_hit));
  endtask

  task automatic fetch_hit(input logic [9:0] a, input logic [31:0] exp_ins);
    cpu_address = a;
    cpu_read = 1'b1;
    #1;
    chk("hit_busy", 32'(cpu_busywait), 32'd0);
    chk("hit_instr", cpu_instruction, exp_ins);
    chk("hit_memrd", 32'(mem_read), 32'd0);
    tick();
    exp_hit++;
    cpu_read = 1'b0;
    chk("hit_count", 32'(hit_count), 32'(exp_hit));
    chk("hit_misscnt", 32'(miss_count), 32'(exp_miss));
  endtask

  initial begin
    for (int b = 0; b < 64; b++) begin
      for (int w = 0; w < 4; w++) begin
        imem[b][w*32 +: 32] = 32'hC0DE_0000 | 32'(b * 16 + w * 4);
      end
    end
    imem[0] = {32'h0305_0101, 32'h0202_0100, 32'h0001_00F7, 32'h0000_0023};
    imem[1][31:0]   = 32'h0104_0003;
    imem[1][127:96] = 32'h0A00_0203;

    reset_n = 1'b0;
    cpu_read = 1'b0;
    cpu_address = 10'h000;
    #3;
    chk("rst_busy", 32'(cpu_busywait), 32'd0);
    chk("rst_memrd", 32'(mem_read), 32'd0);
    chk("rst_memaddr", 32'(mem_address), 32'd0);
    chk("rst_hits", 32'(hit_count), 32'd0);
    chk("rst_misses", 32'(miss_count), 32'd0);
    chk("rst_instr", cpu_instruction, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // Cold miss, then sequential hits in the same block.
    do_miss(10'h000, 6'd0, 32'h0000_0023);
    fetch_hit(10'h004, 32'h0001_00F7);
    fetch_hit(10'h008, 32'h0202_0100);
    fetch_hit(10'h00C, 32'h0305_0101);
    chk("seq_hits", 32'(hit_count), 32'd4);

    // Next block.
    do_miss(10'h010, 6'd1, 32'h0104_0003);
    fetch_hit(10'h01C, 32'h0A00_0203);

    // Conflict on index 0.
    do_miss(10'h080, 6'd8, 32'hC0DE_0080);
    do_miss(10'h000, 6'd0, 32'h0000_0023);
    chk("conflict_misses", 32'(miss_count), 32'd4);

    // Address changes mid-refill: block 3 still installed, new address served after.
    cpu_address = 10'h030;
    cpu_read = 1'b1;
    tick();
    exp_miss++;
    chk("chg_memaddr", 32'(mem_address), 32'd3);
    cpu_address = 10'h004;
    wait_ready("chg_lat");
    chk("chg_instr", cpu_instruction, 32'h0001_00F7);
    tick();
    exp_hit++;
    cpu_read = 1'b0;
    fetch_hit(10'h030, 32'hC0DE_0030);

    // Read dropped mid-refill: the line is still installed.
    cpu_address = 10'h040;
    cpu_read = 1'b1;
    tick();
    exp_miss++;
    cpu_read = 1'b0;
    repeat (5) tick();
    chk("drop_busy", 32'(cpu_busywait), 32'd0);
    chk("drop_memrd", 32'(mem_read), 32'd0);
    fetch_hit(10'h044, 32'hC0DE_0044);

    // Idle cycles with arbitrary addresses.
    for (int i = 0; i < 10; i++) begin
      cpu_address = 10'($urandom_range(0, 1023));
      cpu_read = 1'b0;
      #1;
      chk("idle_busy", 32'(cpu_busywait), 32'd0);
      chk("idle_memrd", 32'(mem_read), 32'd0);
      chk("idle_instr", cpu_instruction, 32'd0);
      tick();
      chk("idle_hits", 32'(hit_count), 32'(exp_hit));
      chk("idle_misses", 32'(miss_count), 32'(exp_miss));
    end

    // Asynchronous reset in the middle of a refill.
    cpu_address = 10'h020;
    cpu_read = 1'b1;
    tick();
    tick();
    chk("pre_rst_memrd", 32'(mem_read), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_memrd", 32'(mem_read), 32'd0);
    chk("arst_busy", 32'(cpu_busywait), 32'd0);
    chk("arst_hits", 32'(hit_count), 32'd0);
    chk("arst_misses", 32'(miss_count), 32'd0);
    chk("arst_memaddr", 32'(mem_address), 32'd0);
    cpu_read = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    exp_hit = 0;
    exp_miss = 0;
    tick();
    do_miss(10'h000, 6'd0, 32'h0000_0023);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/icache_controller.md
Name: icache_controller

Overview:
- Direct-mapped instruction cache and controller between the CPU fetch stage and inst_memory.
- Serves 32-bit instruction fetches from a local block store.
- On a miss, sequences a 16-byte block read from inst_memory over the read/busywait handshake, refills the line, then completes the fetch.
- Stalls the CPU through cpu_busywait; keeps hit/miss counters.

Parameters:
- ADDR_BITS, 10, CPU byte-address width (1024-byte instruction space).
- INDEX_BITS, 3, cache line index width (8 lines).
- BLOCK_BITS, 128, line width; fixed to the inst_memory block size.
- CNT_BITS, 16, width of each performance counter.

Ports:
- clock  in  1  system clock, posedge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_read  in  1  fetch request, level.
- cpu_address  in  ADDR_BITS  fetch byte address (PC); bits [1:0] ignored.
- cpu_instruction  out  32  fetched instruction word.
- cpu_busywait  out  1  CPU stall.
- mem_read  out  1  block read request to inst_memory.
- mem_address  out  ADDR_BITS-4  block address to inst_memory.
- mem_readdata  in  BLOCK_BITS  block from inst_memory.
- mem_busywait  in  1  inst_memory busy.
- hit_count  out  CNT_BITS  completed hits.
- miss_count  out  CNT_BITS  misses started.

Behaviour:
- Reset: asynchronous, active-low; one clock; no other reset.
- Address split: tag = cpu_address[9:7], index = [6:4], word offset = [3:2]; mem_address = {tag, index}.
- Per line state: valid bit, 3-bit tag, 128-bit block.
- Reset (asynchronous, any state, including mid-refill):
  - all valid bits 0; state IDLE.
  - mem_read 0, mem_address 0, hit_count 0, miss_count 0.
  - cpu_busywait 0, cpu_instruction 0.
- Hit = cpu_read & valid[index] & (tag match). Evaluated combinationally.
- FSM states: IDLE, MEM_READ, UPDATE.
- IDLE:
  - cpu_read 0: cpu_busywait 0, cpu_instruction 0, no state change.
  - Hit: cpu_busywait 0 in the same cycle; cpu_instruction = block word [offset] (offset 0 = bits 31:0, offset 3 = bits 127:96); hit_count +1 at posedge.
  - Miss: cpu_busywait 1 combinationally. At posedge: latch {tag, index} into mem_address, miss_count +1, go to MEM_READ.
- MEM_READ:
  - mem_read 1; mem_address held; cpu_busywait 1.
  - Entry cycle: mem_busywait is ignored.
  - Exit: first later posedge with mem_busywait 0 → UPDATE. Capture mem_readdata into the latched line at that same posedge.
- UPDATE (exactly one cycle):
  - Set valid and tag for the latched index; mem_read 0; cpu_busywait 1.
  - Next state IDLE, where the held fetch now hits; hit_count +1 when it completes.
- Miss latency: refill cycles + 2 cycles. A miss therefore also counts one hit when it completes.
- cpu_address changes during a refill: the refill completes for the latched block. The new address is then evaluated in IDLE.
- cpu_read drops during a refill: the refill still completes and the line is installed.
- Conflict miss: the line is overwritten unconditionally. No write-back; instruction memory is read-only.
- Counters saturate at all-ones.
- mem_read is a registered output, never glitching.
- No simultaneous CPU and memory accesses are possible; there is a single outstanding miss.

Decomposition:
- Shared package icache_pkg:
  - state enum {IDLE, MEM_READ, UPDATE}.
  - TAG_BITS = 3, OFFSET_BITS = 2, WORDS_PER_BLOCK = 4.
  - field-extract constants for the tag/index/offset positions.
- Sub-module icache_line_store: valid/tag/data arrays, a 1-cycle write port, a combinational read port and hit compare, and the asynchronous valid clear.
- FSM and counters stay in icache_controller.

Test Plan:
- inst_memory preloaded with the lab program.
- Cold miss: reset, cpu_read=1, address 0x000.
  - cpu_busywait 1 immediately; mem_read 1 with mem_address 0 from the next cycle.
  - After refill and UPDATE: cpu_instruction 0x00000023, cpu_busywait 0, miss_count 1, hit_count 1.
- Sequential hits: addresses 0x004, 0x008, 0x00C, one per cycle.
  - No stall; instructions 0x000100F7, 0x02020100, 0x03050101; hit_count 4, mem_read stays 0.
- Next block: address 0x010.
  - Miss with mem_address 1; instruction 0x01040003; then 0x01C gives 0x0A000203 as a hit.
- Conflict: 0x080 (index 0, tag 1) then 0x000.
  - Two misses, mem_address 8 then 0; miss_count +2; 0x000 returns 0x00000023 again.
- Reset mid-refill: assert reset_n=0 during MEM_READ.
  - mem_read 0, cpu_busywait 0, counters 0 immediately (asynchronous).
  - After release, address 0x000 misses again.
- Idle: cpu_read 0 for 10 cycles with arbitrary addresses.
  - cpu_busywait 0, mem_read 0, counters unchanged.
